// File: rtl/squeeze_output_buffer.sv
// Output buffer for a SHAKE squeeze phase: captures one rate-sized block of
// state lanes and serializes it as 64-bit words until the requested digest length is met.
module squeeze_output_buffer (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_load,
  input  logic          cfg_mode,
  input  logic [15:0]   cfg_out_words,
  input  logic [1343:0] block_in,
  input  logic          block_we,
  output logic          output_buffer_available,
  output logic          last_output_block,
  output logic [63:0]   dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          err_overflow
);

  localparam int NUM_LANES = 21;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EMPTY = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [15:0] remaining;
  logic [4:0]  idx;
  logic [4:0]  blk_words;
  logic        mode;
  logic [63:0] blk_q [NUM_LANES];

  logic [4:0]  rate_words;
  logic [4:0]  nxt_idx;
  logic [4:0]  min_words;
  logic        last_word;
  logic        hs;

  assign rate_words = mode ? 5'd17 : 5'd21;
  assign nxt_idx    = idx + 5'd1;
  assign last_word  = (idx == blk_words - 5'd1);
  assign min_words  = (remaining < {11'd0, rate_words}) ? remaining[4:0] : rate_words;

  // Output handshake: a word transfers on any rising edge where dout_valid and
  // dout_ready are both high; dout_valid never depends on dout_ready, and dout
  // holds its value until the transfer happens.
  assign hs = (state == ST_DRAIN) && dout_ready;

  assign output_buffer_available = (state == ST_EMPTY);
  assign last_output_block       = (state == ST_EMPTY) && (remaining <= {11'd0, rate_words});
  assign dout_valid              = (state == ST_DRAIN);
  assign dout_last               = (state == ST_DRAIN) && (remaining == 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      remaining    <= 16'd0;
      idx          <= 5'd0;
      blk_words    <= 5'd0;
      mode         <= 1'b0;
      err_overflow <= 1'b0;
      dout         <= 64'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            err_overflow <= 1'b0;
            if (cfg_out_words != 16'd0) begin
              mode      <= cfg_mode;
              remaining <= cfg_out_words;
              state     <= ST_EMPTY;
            end
          end
          if (block_we) err_overflow <= 1'b1;
        end
        ST_EMPTY: begin
          if (block_we) begin
            for (int i = 0; i < NUM_LANES; i++) blk_q[i] <= block_in[64*i +: 64];
            blk_words <= min_words;
            idx       <= 5'd0;
            dout      <= block_in[63:0];
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (block_we) err_overflow <= 1'b1;
          if (hs) begin
            remaining <= remaining - 16'd1;
            idx       <= nxt_idx;
            if (last_word) begin
              // Lanes past blk_words in a short final block are dropped here.
              dout  <= 64'd0;
              state <= (remaining == 16'd1) ? ST_IDLE : ST_EMPTY;
            end else begin
              dout <= blk_q[nxt_idx];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_squeeze_output_buffer.sv
// Directed-plus-random bench for squeeze_output_buffer; expected words come
// from a queue model built from each written block and the digest length.
module tb_squeeze_output_buffer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_load;
  logic          cfg_mode;
  logic [15:0]   cfg_out_words;
  logic [1343:0] block_in;
  logic          block_we;
  logic          output_buffer_available;
  logic          last_output_block;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          err_overflow;

  squeeze_output_buffer dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cfg_load                (cfg_load),
    .cfg_mode                (cfg_mode),
    .cfg_out_words           (cfg_out_words),
    .block_in                (block_in),
    .block_we                (block_we),
    .output_buffer_available (output_buffer_available),
    .last_output_block       (last_output_block),
    .dout                    (dout),
    .dout_valid              (dout_valid),
    .dout_ready              (dout_ready),
    .dout_last               (dout_last),
    .err_overflow            (err_overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // reference model state
  logic [63:0] exp_q[$];
  int          model_rem;
  int          model_mode;
  int          n_checks = 0;
  int          n_err    = 0;

  function automatic int model_rate();
    return (model_mode != 0) ? 17 : 21;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic mode, input logic [15:0] words);
    cfg_load      = 1'b1;
    cfg_mode      = mode;
    cfg_out_words = words;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic rand_block(output logic [1343:0] blk);
    for (int i = 0; i < 42; i++) blk[32*i +: 32] = $urandom();
  endtask

  // Writes one random block; the model keeps only the words the digest still needs.
  task automatic write_block(output int n);
    logic [1343:0] blk;
    rand_block(blk);
    n = (model_rem < model_rate()) ? model_rem : model_rate();
    for (int i = 0; i < n; i++) exp_q.push_back(blk[64*i +: 64]);
    block_in = blk;
    block_we = 1'b1;
    tick();
    block_we = 1'b0;
    chk("avail_after_we", output_buffer_available, 1'b0);
  endtask

  // ready_style: 0 = always 1, 1 = random, 2 = repeating 1,0,0,1
  task automatic drain(input int n, input int ready_style, output int cycles);
    int got = 0;
    int budget = n * 10 + 20;
    logic v;
    cycles = 0;
    while (got < n && cycles < budget) begin
      case (ready_style)
        0:       dout_ready = 1'b1;
        1:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = (cycles % 4 == 0) || (cycles % 4 == 3);
      endcase
      v = dout_valid;
      chk("drain_valid", v, 1'b1);
      if (v) begin
        chk("dout", dout, (exp_q.size() > 0) ? exp_q[0] : 64'hx);
        chk("dout_last", dout_last, model_rem == 1);
      end
      tick();
      cycles++;
      if (v && dout_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        model_rem--;
        got++;
      end
    end
    dout_ready = 1'b0;
    chk("drain_count", 64'(got), 64'(n));
  endtask

  task automatic check_idle(input string tag, input logic exp_err);
    chk({tag, "_avail"}, output_buffer_available, 1'b0);
    chk({tag, "_lastblk"}, last_output_block, 1'b0);
    chk({tag, "_valid"}, dout_valid, 1'b0);
    chk({tag, "_dlast"}, dout_last, 1'b0);
    chk({tag, "_err"}, err_overflow, exp_err);
  endtask

  initial begin
    int n;
    int cyc;
    int total;
    logic [1343:0] junk;

    rst_n = 1'b0; cfg_load = 1'b0; cfg_mode = 1'b0; cfg_out_words = 16'd0;
    block_in = '0; block_we = 1'b0; dout_ready = 1'b0;
    model_rem = 0; model_mode = 0;
    tick(); tick();
    rst_n = 1'b1;
    check_idle("reset", 1'b0);
    chk("reset_dout", dout, 64'd0);

    // SHAKE128, 4 words, ready tied high
    do_cfg(1'b0, 16'd4); model_mode = 0; model_rem = 4;
    chk("s128_avail", output_buffer_available, 1'b1);
    chk("s128_lastblk", last_output_block, 1'b1);
    write_block(n);
    drain(n, 0, cyc);
    chk("s128_cycles", 64'(cyc), 64'd4);
    check_idle("s128_end", 1'b0);

    // SHAKE256, 40 words over three blocks
    do_cfg(1'b1, 16'd40); model_mode = 1; model_rem = 40; total = 0;
    for (int b = 0; b < 3; b++) begin
      chk("s256_avail", output_buffer_available, 1'b1);
      chk("s256_lastblk", last_output_block, model_rem <= model_rate());
      write_block(n);
      drain(n, 1, cyc);
      total += n;
    end
    chk("s256_total", 64'(total), 64'd40);
    check_idle("s256_end", 1'b0);

    // backpressure pattern 1,0,0,1
    do_cfg(1'($urandom_range(0, 1)), 16'(5 + $urandom_range(0, 20)));
    model_mode = int'(cfg_mode); model_rem = int'(cfg_out_words);
    while (model_rem > 0) begin
      chk("bp_avail", output_buffer_available, 1'b1);
      write_block(n);
      drain(n, 2, cyc);
    end
    check_idle("bp_end", 1'b0);

    // overflow: block_we during DRAIN
    do_cfg(1'b0, 16'd8); model_mode = 0; model_rem = 8;
    write_block(n);
    drain(2, 1, cyc);
    rand_block(junk);
    block_in = junk; block_we = 1'b1;
    tick();
    block_we = 1'b0;
    chk("ovf_flag", err_overflow, 1'b1);
    drain(6, 1, cyc);
    check_idle("ovf_end", 1'b1);
    do_cfg(1'b1, 16'd0);
    check_idle("ovf_clear", 1'b0);

    // cfg_load during DRAIN is ignored
    do_cfg(1'b0, 16'd10); model_mode = 0; model_rem = 10;
    write_block(n);
    drain(3, 0, cyc);
    cfg_load = 1'b1; cfg_mode = 1'b1; cfg_out_words = 16'd2;
    tick();
    cfg_load = 1'b0;
    chk("cfgdrain_valid", dout_valid, 1'b1);
    chk("cfgdrain_avail", output_buffer_available, 1'b0);
    drain(7, 1, cyc);
    check_idle("cfgdrain_end", 1'b0);

    // reset after 2 of 10 words
    do_cfg(1'b0, 16'd10); model_mode = 0; model_rem = 10;
    write_block(n);
    drain(2, 0, cyc);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete(); model_rem = 0; model_mode = 0;
    check_idle("rst_mid", 1'b0);
    chk("rst_mid_dout", dout, 64'd0);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_quiet_valid", dout_valid, 1'b0);
    end
    dout_ready = 1'b0;
    block_in = junk; block_we = 1'b1;
    tick();
    block_we = 1'b0;
    check_idle("rst_we_idle", 1'b1);
    do_cfg(1'b1, 16'd2); model_mode = 1; model_rem = 2;
    chk("rst_new_err", err_overflow, 1'b0);
    write_block(n);
    drain(n, 1, cyc);
    check_idle("rst_new_end", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
